// File: rtl/kronos_hcu.sv
// Hazard control unit for the Kronos decode stage: per-register pending-write
// scoreboard, RAW/full stall generation, flush unwind of the ID/EX writer.
module kronos_hcu #(
  parameter int MAX_PEND                = 3,
  parameter bit USE_REGISTER_FORWARDING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_vld,
  input  logic [4:0]  id_rs1,
  input  logic        id_rs1_en,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs2_en,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_wr,
  input  logic        ex_free,
  input  logic        ex_adv,
  input  logic        flush,
  input  logic        regwr_en,
  input  logic [4:0]  regwr_sel,
  output logic        stall,
  output logic        issue,
  output logic [31:0] pending,
  output logic        err
);

  localparam int            CW      = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt     [32];
  logic [CW-1:0] cnt_nxt [32];
  logic          idex_vld;
  logic [4:0]    idex_rd;
  logic          fwd1, fwd2, raw1, raw2, full, kill, bound_err;

  // Hazard detection; x0 is never counted, so a nonzero index guard suffices.
  always_comb begin
    fwd1  = USE_REGISTER_FORWARDING && regwr_en && (regwr_sel == id_rs1) &&
            (cnt[id_rs1] == CNT_ONE);
    fwd2  = USE_REGISTER_FORWARDING && regwr_en && (regwr_sel == id_rs2) &&
            (cnt[id_rs2] == CNT_ONE);
    raw1  = id_rs1_en && (id_rs1 != 5'd0) && (cnt[id_rs1] != '0) && !fwd1;
    raw2  = id_rs2_en && (id_rs2 != 5'd0) && (cnt[id_rs2] != '0) && !fwd2;
    full  = id_rd_wr && (id_rd != 5'd0) && (cnt[id_rd] == CNT_MAX);
    stall = id_vld && (raw1 || raw2 || full);
    issue = id_vld && ex_free && !stall && !flush;
    kill  = flush && idex_vld && !ex_adv;
  end

  // NOTE: all three events are summed before bounding so a same-cycle
  // retire and re-issue of one register nets to zero instead of erroring.
  always_comb begin
    int net;
    net        = 0;
    bound_err  = 1'b0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < 32; r++) begin
      net = int'(cnt[r]);
      if (issue && id_rd_wr && (id_rd == 5'(r))) net = net + 1;
      if (regwr_en && (regwr_sel == 5'(r)))      net = net - 1;
      if (kill && (idex_rd == 5'(r)))            net = net - 1;
      if (net < 0) begin
        bound_err  = 1'b1;
        cnt_nxt[r] = '0;
      end else if (net > MAX_PEND) begin
        bound_err  = 1'b1;
        cnt_nxt[r] = CNT_MAX;
      end else begin
        cnt_nxt[r] = CW'(net);
      end
    end
  end

  // NOTE: the scoreboard is an array of flops, not a RAM, and must be reset so
  // that no register appears pending out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      idex_vld <= 1'b0;
      idex_rd  <= 5'd0;
      err      <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      err <= err | bound_err;
      if (issue) begin
        idex_vld <= id_rd_wr && (id_rd != 5'd0);
        idex_rd  <= id_rd;
      end else if (ex_adv || flush) begin
        idex_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    pending[0] = 1'b0;
    for (int r = 1; r < 32; r++) pending[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_kronos_hcu.sv
// Directed bench for kronos_hcu: a forwarding instance and a non-forwarding
// instance share stimulus; expected values are hand-computed per step.
module tb_kronos_hcu;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_vld, id_rs1_en, id_rs2_en, id_rd_wr;
  logic [4:0]  id_rs1, id_rs2, id_rd, regwr_sel;
  logic        ex_free, ex_adv, flush, regwr_en;
  logic        stall, issue, err;
  logic [31:0] pending;
  logic        nf_stall, nf_issue, nf_err;
  logic [31:0] nf_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kronos_hcu #(.MAX_PEND(3), .USE_REGISTER_FORWARDING(1'b1)) u_dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .ex_free(ex_free), .ex_adv(ex_adv), .flush(flush), .regwr_en(regwr_en),
    .regwr_sel(regwr_sel), .stall(stall), .issue(issue), .pending(pending), .err(err)
  );

  kronos_hcu #(.MAX_PEND(3), .USE_REGISTER_FORWARDING(1'b0)) u_nf (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .ex_free(ex_free), .ex_adv(ex_adv), .flush(flush), .regwr_en(regwr_en),
    .regwr_sel(regwr_sel), .stall(nf_stall), .issue(nf_issue), .pending(nf_pending),
    .err(nf_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and are checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_vld = 1'b0; id_rs1 = 5'd0; id_rs1_en = 1'b0; id_rs2 = 5'd0; id_rs2_en = 1'b0;
    id_rd = 5'd0; id_rd_wr = 1'b0; ex_free = 1'b1; ex_adv = 1'b0; flush = 1'b0;
    regwr_en = 1'b0; regwr_sel = 5'd0;
  endtask

  task automatic writer(input logic [4:0] rd);
    id_vld = 1'b1; id_rd = rd; id_rd_wr = 1'b1;
    id_rs1 = 5'd0; id_rs1_en = 1'b1; id_rs2 = 5'd0; id_rs2_en = 1'b1;
  endtask

  task automatic retire(input logic [4:0] sel);
    regwr_en = 1'b1; regwr_sel = sel;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_pending", pending, 32'h0);
    check("rst_err", {31'd0, err}, 32'd0);
    id_vld = 1'b1; id_rs1 = 5'd5; id_rs1_en = 1'b1; id_rs2 = 5'd9; id_rs2_en = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_issue", {31'd0, issue}, 32'd1);
    flush = 1'b1;
    #1;
    check("rst_flush_issue", {31'd0, issue}, 32'd0);
    tick();
    idle();

    // Independent stream rd=1,2,3 with x0 sources.
    writer(5'd1);
    #1;
    check("ind_stall1", {31'd0, stall}, 32'd0);
    check("ind_issue1", {31'd0, issue}, 32'd1);
    tick();
    check("ind_pend1", pending, 32'h2);
    writer(5'd2); ex_adv = 1'b1;
    #1;
    check("ind_stall2", {31'd0, stall}, 32'd0);
    tick();
    writer(5'd3);
    #1;
    check("ind_stall3", {31'd0, stall}, 32'd0);
    tick();
    idle(); ex_adv = 1'b1;
    check("ind_pend3", pending, 32'h0000000E);
    tick();
    idle();
    retire(5'd1); tick();
    retire(5'd2); tick();
    retire(5'd3); tick();
    idle();
    check("ind_pend_clr", pending, 32'h0);
    check("ind_err", {31'd0, err}, 32'd0);

    // RAW on r5: forwarding issues in the retire cycle, no-forwarding one later.
    writer(5'd5); id_rs1_en = 1'b0; id_rs2_en = 1'b0;
    tick();
    idle();
    id_vld = 1'b1; id_rs1 = 5'd5; id_rs1_en = 1'b1; ex_adv = 1'b1;
    #1;
    check("raw_stall_first", {31'd0, stall}, 32'd1);
    check("raw_nf_stall_first", {31'd0, nf_stall}, 32'd1);
    tick();
    ex_adv = 1'b0;
    #1;
    check("raw_stall_hold", {31'd0, stall}, 32'd1);
    check("raw_issue_hold", {31'd0, issue}, 32'd0);
    tick();
    retire(5'd5);
    #1;
    check("raw_fwd_stall", {31'd0, stall}, 32'd0);
    check("raw_fwd_issue", {31'd0, issue}, 32'd1);
    check("raw_nf_stall", {31'd0, nf_stall}, 32'd1);
    check("raw_nf_issue", {31'd0, nf_issue}, 32'd0);
    tick();
    regwr_en = 1'b0;
    #1;
    check("raw_nf_issue_late", {31'd0, nf_issue}, 32'd1);
    check("raw_pend", pending, 32'h0);
    check("raw_nf_pend", nf_pending, 32'h0);
    tick();
    idle();

    // x0 destination and x0 source.
    writer(5'd0); ex_adv = 1'b1;
    #1;
    check("x0_stall", {31'd0, stall}, 32'd0);
    check("x0_issue", {31'd0, issue}, 32'd1);
    tick();
    idle();
    check("x0_pend", pending, 32'h0);

    // Saturation on r7 (MAX_PEND=3).
    for (int i = 0; i < 3; i++) begin
      writer(5'd7); ex_adv = 1'b1;
      tick();
    end
    #1;
    check("sat_stall4", {31'd0, stall}, 32'd1);
    check("sat_issue4", {31'd0, issue}, 32'd0);
    check("sat_pend", pending, 32'h80);
    tick();
    check("sat_stall_hold", {31'd0, stall}, 32'd1);
    retire(5'd7);
    #1;
    check("sat_stall_retire", {31'd0, stall}, 32'd1);
    tick();
    regwr_en = 1'b0;
    #1;
    check("sat_stall_after", {31'd0, stall}, 32'd0);
    check("sat_issue_after", {31'd0, issue}, 32'd1);
    tick();
    idle(); ex_adv = 1'b1;
    check("sat_err", {31'd0, err}, 32'd0);
    retire(5'd7);
    tick();
    // Retire and new writer of r7 together: count stays at 2.
    writer(5'd7); ex_adv = 1'b1; retire(5'd7);
    #1;
    check("same_cyc_issue", {31'd0, issue}, 32'd1);
    tick();
    idle(); ex_adv = 1'b1;
    retire(5'd7); tick();
    regwr_en = 1'b0;
    check("same_cyc_pend_mid", pending, 32'h80);
    retire(5'd7); tick();
    regwr_en = 1'b0;
    check("same_cyc_pend_clr", pending, 32'h0);
    check("same_cyc_err", {31'd0, err}, 32'd0);
    tick();
    idle();

    // Flush of r9 writer still in ID/EX register.
    writer(5'd9);
    tick();
    idle(); ex_free = 1'b0;
    tick();
    flush = 1'b1;
    check("fl_pend_before", pending, 32'h200);
    tick();
    flush = 1'b0;
    check("fl_kill_pend", pending, 32'h0);
    check("fl_kill_err", {31'd0, err}, 32'd0);
    ex_free = 1'b1;
    writer(5'd9);
    tick();
    idle(); flush = 1'b1; ex_adv = 1'b1;
    tick();
    idle();
    check("fl_adv_pend", pending, 32'h200);
    tick();
    check("fl_adv_pend_hold", pending, 32'h200);
    retire(5'd9);
    tick();
    idle();
    check("fl_adv_pend_clr", pending, 32'h0);
    check("fl_adv_err", {31'd0, err}, 32'd0);

    // Underflow on r12.
    retire(5'd12);
    #1;
    check("uf_err_before", {31'd0, err}, 32'd0);
    tick();
    idle();
    check("uf_err", {31'd0, err}, 32'd1);
    check("uf_pend", pending, 32'h0);
    tick(); tick();
    check("uf_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    check("uf_err_rst", {31'd0, err}, 32'd0);
    check("uf_nf_err_rst", {31'd0, nf_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kronos_hcu.md
# kronos_hcu

Hazard control unit for the Kronos decode stage. It keeps a scoreboard of in-flight register writes and gates the ID issue handshake. An instruction stalls in ID while any source register it reads has an older write still pending. The HCU also unwinds the scoreboard entry of an instruction killed by a pipeline flush, and sits between the fetch/decode handshake and the register-file write port.

## Interface

Parameters:
- MAX_PEND, 3: maximum outstanding writes tracked per register; counter width is clog2(MAX_PEND+1).
- USE_REGISTER_FORWARDING, 1: when 1, a source being written back in the current cycle with exactly one pending write does not stall.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- id_vld  in  1  instruction present in ID (fetch_vld)
- id_rs1  in  5  source 1 index
- id_rs1_en  in  1  instruction reads rs1
- id_rs2  in  5  source 2 index
- id_rs2_en  in  1  instruction reads rs2
- id_rd  in  5  destination index
- id_rd_wr  in  1  instruction writes rd (is_reg_write)
- ex_free  in  1  ID/EX register can accept (~decode_vld | decode_rdy)
- ex_adv  in  1  ID/EX instruction accepted by EX (decode_vld & decode_rdy)
- flush  in  1  kill instruction in ID and in ID/EX register
- regwr_en  in  1  register-file write this cycle
- regwr_sel  in  5  register-file write index
- stall  out  1  hold ID (combinational)
- issue  out  1  ID instruction issues this cycle (combinational)
- pending  out  32  per-register nonzero-count vector, bit 0 always 0
- err  out  1  sticky scoreboard underflow/overflow flag

## Operation

- Scoreboard: cnt[r] for r=1..31; r=0 never counted, never stalls.
- raw1 = id_rs1_en & id_rs1!=0 & cnt[id_rs1]!=0 & ~fwd1, where fwd1 = USE_REGISTER_FORWARDING & regwr_en & regwr_sel==id_rs1 & cnt[id_rs1]==1. raw2 is defined the same way for rs2.
- full = id_rd_wr & id_rd!=0 & cnt[id_rd]==MAX_PEND.
- stall = id_vld & (raw1 | raw2 | full).
- issue = id_vld & ex_free & ~stall & ~flush.
- Per-cycle update of cnt[r]: +1 if issue & id_rd_wr & id_rd==r; −1 if regwr_en & regwr_sel==r; −1 if kill & idex_rd==r. All three events combine with net arithmetic in one cycle; a net of 0 leaves cnt unchanged.
- ID/EX tracker: idex_vld and idex_rd are registers.
  - On issue, they load id_rd_wr & id_rd!=0 and id_rd.
  - Else on ex_adv or flush, idex_vld clears.
- kill = flush & idex_vld & ~ex_adv.
  - An instruction that advances in the same cycle as flush is in EX and retires normally, so it is not killed.
  - An instruction still in ID at flush was never counted.
- err sets on any decrement of a zero count or any increment beyond MAX_PEND. It clears only on rst. The affected counter saturates, with no wrap.
- pending[r] = cnt[r]!=0 (registered state, no combinational path).

## Timing

- Reset: all cnt=0, idex_vld=0, idex_rd=0, err=0, so pending=0.
  - stall is then 0 regardless of source indices.
  - issue = id_vld & ex_free & ~flush.
- stall and issue are combinational from inputs and current state. There is no register in the stall path, so zero-cycle hold.
- Scoreboard update is visible the cycle after the issue, retire or kill edge.
  - A dependent instruction directly behind a writer stalls from its first cycle in ID.
- Write-back bypass (USE_REGISTER_FORWARDING=1): the consumer issues in the retire cycle. With USE_REGISTER_FORWARDING=0 it issues the cycle after.
- Retire of register r while a new writer of r issues the same cycle: the count is unchanged.
- rst asserted mid-operation clears all state asynchronously. In-flight writes then retiring decrement zero counts and set err, so the pipeline must be reset together.

## Test plan

- Reset then independent stream (rd=1,2,3; sources x0): stall never asserts, pending=0x0000000E after three issues, returns to 0 after three retires.
- RAW: issue writer rd=5; next cycle id_rs1=5, id_rs1_en=1 -> stall=1 until regwr_en,sel=5. Issue occurs that cycle with forwarding=1, one cycle later with forwarding=0.
- x0: id_rd=0 writes never set pending; id_rs2=0 with rs2_en=1 never stalls.
- Saturation (MAX_PEND=3): four writers to rd=7 with no retire -> fourth stalls with stall=1 until one retire of r7, then issues; err stays 0.
- Flush: issue rd=9 with ex_free held low, flush with ex_adv=0 -> cnt[9] back to 0, pending[9]=0. Repeat with ex_adv=1 in the flush cycle -> pending[9] stays 1 until retire.
- Underflow: regwr_en,sel=12 with cnt[12]=0 -> err=1 next cycle, cnt[12] stays 0, err held until rst.
